ahb_slave_resp: RTL and testbench

AHB_SLAVE_RESP -- requirements
Module: ahb_slave_resp

---
 rtl/ahb_slave_resp.sv | 198 +++++++++++++++++++
 tb/tb_ahb_slave_resp.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_resp.sv
// ----------------------------------------------------------------------------
// ahb_slave_resp
//
// AHB-Lite slave with a 16 x 32-bit memory window and a programmable number of
// wait states. Each accepted beat is decoded on its own: an out-of-window or
// misaligned/oversized beat gets the two-cycle ERROR response. A legal beat
// completes after WAIT_STATES low cycles of HREADYOUT.
//
// Parameters
//   WAIT_STATES  HREADYOUT-low cycles per OKAY transfer (0..7)
//   ADDR_BASE    base of the 64-byte window, decoded on HADDR[31:6]
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   HSEL       slave select
//   HADDR      address-phase byte address
//   HTRANS     transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE     1 = write
//   HSIZE      000 byte, 001 half, 010 word
//   HBURST     accepted and ignored
//   HWDATA     write data (data phase)
//   HREADY     bus-level ready
//   HREADYOUT  slave ready
//   HRESP      00 OKAY, 01 ERROR
//   HRDATA     read data
// ----------------------------------------------------------------------------
module ahb_slave_resp #(
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    // Data-phase context captured at the address-phase edge.
    logic [5:0]  addr_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        valid_q;   // a legal data phase is in progress

    logic [31:0] mem_q [16];

    logic        slave_ready;
    logic        accept;
    logic        illegal;
    logic        wr_en;
    logic [3:0]  be;
    logic [31:0] rd_word;
    logic [31:0] wr_word;

    // Burst type carries no information for a beat-by-beat decoder.
    logic        unused_hburst;
    assign unused_hburst = ^HBURST;

    // Ready depends only on state, which keeps the accept path free of loops.
    assign slave_ready = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign HREADYOUT   = slave_ready;
    assign HRESP       = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;

    // Address inputs while we hold HREADYOUT low are never sampled.
    assign accept = HSEL & HREADY & HTRANS[1] & slave_ready;

    always_comb begin
        illegal = 1'b0;
        if (HADDR[31:6] != ADDR_BASE[31:6])
            illegal = 1'b1;
        if (HSIZE[2] || (HSIZE == 3'b011))
            illegal = 1'b1;
        if ((HSIZE == 3'b001) && HADDR[0])
            illegal = 1'b1;
        if ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00))
            illegal = 1'b1;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 3'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                // Leaving at count 1 gives exactly WAIT_STATES low cycles.
                if (cnt_q <= 3'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Data-phase context
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= 6'd0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            valid_q <= 1'b0;
        end else if (slave_ready) begin
            if (accept) begin
                addr_q  <= HADDR[5:0];
                write_q <= HWRITE;
                size_q  <= HSIZE[1:0];
                valid_q <= ~illegal;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory
    // ------------------------------------------------------------------
    assign rd_word = mem_q[addr_q[5:2]];

    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Merge the enabled lanes of HWDATA over the current word contents.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_word[gi*8 +: 8] = be[gi] ? HWDATA[gi*8 +: 8] : rd_word[gi*8 +: 8];
        end
    endgenerate

    // Commit happens on the completing edge only, so a read accepted at the
    // same edge sees the new value in its own data phase.
    assign wr_en = valid_q & write_q & slave_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < 16; w++)
                mem_q[w] <= 32'd0;
        end else if (wr_en) begin
            mem_q[addr_q[5:2]] <= wr_word;
        end
    end

    assign HRDATA = (valid_q && !write_q && ((state_q == ST_IDLE) || (state_q == ST_WAIT)))
                    ? rd_word : 32'd0;

endmodule

// File: tb/tb_ahb_slave_resp.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_resp
//
// Three instances (WAIT_STATES = 0, 3, 2) each act as the only slave on their
// own bus, with HREADY looped back from HREADYOUT. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_ahb_slave_resp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [3];
    logic        hsel     [3];
    logic [31:0] haddr    [3];
    logic [1:0]  htrans   [3];
    logic        hwrite   [3];
    logic [2:0]  hsize    [3];
    logic [31:0] hwdata   [3];
    logic        hready_o [3];
    logic [1:0]  hresp    [3];
    logic [31:0] hrdata   [3];

    int errors = 0;
    int checks = 0;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            ahb_slave_resp #(
                .WAIT_STATES((gi == 0) ? 0 : ((gi == 1) ? 3 : 2)),
                .ADDR_BASE  (32'h0000_0000)
            ) u_dut (
                .clk       (clk),
                .reset     (rst[gi]),
                .HSEL      (hsel[gi]),
                .HADDR     (haddr[gi]),
                .HTRANS    (htrans[gi]),
                .HWRITE    (hwrite[gi]),
                .HSIZE     (hsize[gi]),
                .HBURST    (3'b000),
                .HWDATA    (hwdata[gi]),
                .HREADY    (hready_o[gi]),
                .HREADYOUT (hready_o[gi]),
                .HRESP     (hresp[gi]),
                .HRDATA    (hrdata[gi])
            );
        end
    endgenerate

    // Results of the last transfer helper call.
    int          lw;
    logic [1:0]  fr;
    logic [1:0]  rs;
    logic [31:0] rd;

    task automatic drive_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        hwrite[d] = 1'b0;
        hsize[d]  = 3'b000;
        haddr[d]  = 32'd0;
    endtask

    task automatic drive_addr(input int d, input logic w, input logic [2:0] sz,
                              input logic [31:0] a);
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        hwrite[d] = w;
        hsize[d]  = sz;
        haddr[d]  = a;
    endtask

    // From just after an edge in a data phase: count low cycles up to the
    // completing cycle (bounded), capture first and final responses.
    task automatic complete(input int d);
        lw = 0;
        @(negedge clk);
        fr = hresp[d];
        while (hready_o[d] !== 1'b1 && lw < 20) begin
            lw++;
            @(negedge clk);
        end
        rd = hrdata[d];
        rs = hresp[d];
    endtask

    // Single non-pipelined transfer; returns via lw/fr/rs/rd.
    task automatic xfer(input int d, input logic w, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
        drive_addr(d, w, sz, a);
        @(posedge clk); #1;
        drive_idle(d);
        hwdata[d] = wd;
        complete(d);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 3; d++) begin
            if (hready_o[d] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d] got=%b exp=1", d, hready_o[d]); end
            checks++;
            if (hresp[d] !== 2'b00) begin errors++; $display("FAIL reset_resp[%0d] got=%b exp=00", d, hresp[d]); end
            checks++;
            if (hrdata[d] !== 32'd0) begin errors++; $display("FAIL reset_rdata[%0d] got=%h exp=0", d, hrdata[d]); end
            checks++;
        end
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        // First transfer right after reset release.
        xfer(0, 1'b0, 3'b010, 32'h3C, 32'd0);
        if (rd !== 32'd0 || lw !== 0) begin errors++; $display("FAIL reset_mem rdata=%h lows=%0d exp 0/0", rd, lw); end
        checks++;
        $display("test_reset done");
    endtask

    task automatic test_wait3;
        xfer(1, 1'b0, 3'b010, 32'h04, 32'd0);
        if (lw !== 3) begin errors++; $display("FAIL wait3_lows got=%0d exp=3", lw); end
        checks++;
        if (fr !== 2'b00) begin errors++; $display("FAIL wait3_resp_wait got=%b exp=00", fr); end
        checks++;
        if (rs !== 2'b00) begin errors++; $display("FAIL wait3_resp got=%b exp=00", rs); end
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL wait3_rdata got=%h exp=0", rd); end
        checks++;
        $display("test_wait3 read 0x04 lows=%0d rdata=%h", lw, rd);
    endtask

    task automatic test_back_to_back;
        drive_addr(0, 1'b1, 3'b010, 32'h08);
        @(posedge clk); #1;
        hwdata[0] = 32'hDEADBEEF;
        drive_addr(0, 1'b0, 3'b010, 32'h08);
        @(negedge clk);
        if (hready_o[0] !== 1'b1 || hresp[0] !== 2'b00) begin
            errors++; $display("FAIL b2b_write ready=%b resp=%b exp 1/00", hready_o[0], hresp[0]);
        end
        checks++;
        @(posedge clk); #1;
        drive_idle(0);
        @(negedge clk);
        if (hready_o[0] !== 1'b1 || hresp[0] !== 2'b00) begin
            errors++; $display("FAIL b2b_read ready=%b resp=%b exp 1/00", hready_o[0], hresp[0]);
        end
        checks++;
        if (hrdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata got=%h exp=deadbeef", hrdata[0]); end
        checks++;
        @(posedge clk); #1;
        $display("test_back_to_back ws0 write/read 0x08");
    endtask

    task automatic test_pipelined_wait;
        drive_addr(1, 1'b1, 3'b010, 32'h20);
        @(posedge clk); #1;
        hwdata[1] = 32'h0000A5A5;
        drive_addr(1, 1'b0, 3'b010, 32'h20);
        complete(1);
        if (lw !== 3 || rs !== 2'b00) begin errors++; $display("FAIL pipe_write lows=%0d resp=%b exp 3/00", lw, rs); end
        checks++;
        @(posedge clk); #1;
        drive_idle(1);
        complete(1);
        if (lw !== 3) begin errors++; $display("FAIL pipe_read_lows got=%0d exp=3", lw); end
        checks++;
        if (rd !== 32'h0000A5A5) begin errors++; $display("FAIL pipe_read_rdata got=%h exp=0000a5a5", rd); end
        checks++;
        @(posedge clk); #1;
        $display("test_pipelined_wait ws3 write/read 0x20 rdata=%h", rd);
    endtask

    task automatic test_lanes;
        xfer(0, 1'b1, 3'b000, 32'h11, 32'h0000AA00);
        xfer(0, 1'b1, 3'b001, 32'h12, 32'h12340000);
        xfer(0, 1'b0, 3'b010, 32'h10, 32'd0);
        if (rd !== 32'h1234AA00) begin errors++; $display("FAIL lanes_10 got=%h exp=1234aa00", rd); end
        checks++;
        xfer(0, 1'b1, 3'b010, 32'h14, 32'h11223344);
        xfer(0, 1'b1, 3'b000, 32'h17, 32'h99000000);
        xfer(0, 1'b1, 3'b001, 32'h14, 32'h0000BEEF);
        xfer(0, 1'b0, 3'b010, 32'h14, 32'd0);
        if (rd !== 32'h9922BEEF) begin errors++; $display("FAIL lanes_14 got=%h exp=9922beef", rd); end
        checks++;
        $display("test_lanes 0x10=%h", rd);
    endtask

    task automatic test_errors;
        xfer(0, 1'b1, 3'b010, 32'h40, 32'hFFFFFFFF);
        if (lw !== 1 || fr !== 2'b01) begin errors++; $display("FAIL err_oow_err1 lows=%0d resp=%b exp 1/01", lw, fr); end
        checks++;
        if (rs !== 2'b01) begin errors++; $display("FAIL err_oow_err2 resp=%b exp=01", rs); end
        checks++;
        xfer(0, 1'b0, 3'b010, 32'h00, 32'd0);
        if (rd !== 32'd0 || rs !== 2'b00) begin errors++; $display("FAIL err_oow_mem rdata=%h resp=%b exp 0/00", rd, rs); end
        checks++;
        xfer(0, 1'b1, 3'b010, 32'h02, 32'hFFFFFFFF);
        if (lw !== 1 || fr !== 2'b01) begin errors++; $display("FAIL err_mis_err1 lows=%0d resp=%b exp 1/01", lw, fr); end
        checks++;
        if (rs !== 2'b01) begin errors++; $display("FAIL err_mis_err2 resp=%b exp=01", rs); end
        checks++;
        xfer(0, 1'b0, 3'b010, 32'h00, 32'd0);
        if (rd !== 32'd0) begin errors++; $display("FAIL err_mis_mem got=%h exp=0", rd); end
        checks++;
        xfer(0, 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF);
        if (rs !== 2'b01) begin errors++; $display("FAIL err_half_mis resp=%b exp=01", rs); end
        checks++;
        xfer(0, 1'b0, 3'b011, 32'h08, 32'd0);
        if (rs !== 2'b01 || rd !== 32'd0) begin errors++; $display("FAIL err_size_read resp=%b rdata=%h exp 01/0", rs, rd); end
        checks++;
        xfer(0, 1'b0, 3'b010, 32'h10, 32'd0);
        if (rd !== 32'h1234AA00) begin errors++; $display("FAIL err_half_mem got=%h exp=1234aa00", rd); end
        checks++;
        $display("test_errors done");
    endtask

    task automatic test_reset_wait;
        drive_addr(2, 1'b1, 3'b010, 32'h00);
        @(posedge clk); #1;
        drive_idle(2);
        hwdata[2] = 32'h00000055;
        @(negedge clk);
        if (hready_o[2] !== 1'b0) begin errors++; $display("FAIL rstw_in_wait ready=%b exp=0", hready_o[2]); end
        checks++;
        rst[2] = 1'b1;
        #1;
        if (hready_o[2] !== 1'b1 || hresp[2] !== 2'b00 || hrdata[2] !== 32'd0) begin
            errors++; $display("FAIL rstw_outputs ready=%b resp=%b rdata=%h exp 1/00/0", hready_o[2], hresp[2], hrdata[2]);
        end
        checks++;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        xfer(2, 1'b0, 3'b010, 32'h00, 32'd0);
        if (lw !== 2) begin errors++; $display("FAIL rstw_lows got=%0d exp=2", lw); end
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL rstw_mem got=%h exp=0", rd); end
        checks++;
        $display("test_reset_wait readback=%h", rd);
    endtask

    task automatic test_idle_busy;
        hsel[0] = 1'b1; htrans[0] = 2'b01; hwrite[0] = 1'b1;
        hsize[0] = 3'b010; haddr[0] = 32'h08; hwdata[0] = 32'd0;
        @(posedge clk); #1;
        htrans[0] = 2'b00;
        @(negedge clk);
        if (hready_o[0] !== 1'b1 || hresp[0] !== 2'b00) begin
            errors++; $display("FAIL busy ready=%b resp=%b exp 1/00", hready_o[0], hresp[0]);
        end
        checks++;
        @(posedge clk); #1;
        drive_idle(0);
        @(negedge clk);
        if (hready_o[0] !== 1'b1 || hresp[0] !== 2'b00) begin
            errors++; $display("FAIL idle ready=%b resp=%b exp 1/00", hready_o[0], hresp[0]);
        end
        checks++;
        @(posedge clk); #1;
        xfer(0, 1'b0, 3'b010, 32'h08, 32'd0);
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_mem got=%h exp=deadbeef", rd); end
        checks++;
        $display("test_idle_busy 0x08=%h", rd);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d]    = 1'b1;
            hwdata[d] = 32'd0;
            drive_idle(d);
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_wait3;
        test_back_to_back;
        test_pipelined_wait;
        test_lanes;
        test_errors;
        test_reset_wait;
        test_idle_busy;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
